// File: rtl/func_accum_stage_if.sv
// Handshake bundle for func_accum_stage.
//   in_valid/in_ready/in_data                 operand stream into the stage
//   out_valid/out_ready/out_data/out_overflow result stream out of the stage
//   busy                                      stage is not idle
// slave  : the accumulator stage itself
// master : whatever feeds operands and drains results
interface func_accum_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, busy
  );
endinterface

// File: rtl/func_accum_stage.sv
// Shared transform package plus the func_accum_stage accumulator.
//
// func_accum_stage: takes WIDTH-bit operands over a valid/ready handshake,
// applies step() to each, sums COUNT of them and offers the sum (with a
// sticky carry flag) over a second valid/ready handshake.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    func_accum_stage_if.slave (operand in, result out, busy)
//
// state | meaning
// IDLE  | no partial sum; waiting for the first operand of a result
// ACC   | partial sum held, cnt operands accumulated so far
// HOLD  | result complete and presented on out_*, waiting for drain

package func_accum_stage_pkg;
  // Computed at 64 bits so any stage width up to 64 can truncate the result.
  function automatic logic [63:0] step(input logic [63:0] v, input logic [63:0] inc);
    return v + inc;
  endfunction
endpackage

module func_accum_stage #(
  parameter int          WIDTH = 32,
  parameter int unsigned COUNT = 4,
  parameter int unsigned INC   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  func_accum_stage_if.slave    bus
);
  import func_accum_stage_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  localparam logic [7:0] COUNT_C = 8'(COUNT);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;

  logic [WIDTH-1:0] step_v;
  logic [WIDTH:0]   sum;
  logic             in_ready_c;
  logic             in_fire;
  logic             out_fire;

  // Carry out of step() itself falls away in the truncation.
  assign step_v = WIDTH'(step(64'(bus.in_data), 64'(INC)));
  assign sum    = {1'b0, acc} + {1'b0, step_v};

  assign in_ready_c = (state == S_HOLD) ? bus.out_ready : 1'b1;
  assign in_fire    = bus.in_valid && in_ready_c;
  assign out_fire   = (state == S_HOLD) && bus.out_ready;

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state == S_HOLD);
  assign bus.out_data     = acc;
  assign bus.out_overflow = ovf;
  assign bus.busy         = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    unique case (state)
      S_IDLE: begin
        if (in_fire) begin
          acc_nxt   = step_v;
          ovf_nxt   = 1'b0;
          cnt_nxt   = 8'd1;
          state_nxt = (COUNT_C == 8'd1) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (in_fire) begin
          acc_nxt = sum[WIDTH-1:0];
          ovf_nxt = ovf | sum[WIDTH];
          cnt_nxt = cnt + 8'd1;
          if (cnt + 8'd1 == COUNT_C) begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_fire) begin
          if (in_fire) begin
            // Drain and first sample of the next result share this edge.
            acc_nxt   = step_v;
            ovf_nxt   = 1'b0;
            cnt_nxt   = 8'd1;
            state_nxt = (COUNT_C == 8'd1) ? S_HOLD : S_ACC;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_func_accum_stage.sv
module tb_func_accum_stage;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  func_accum_stage_if #(.WIDTH(32)) b4 ();
  func_accum_stage_if #(.WIDTH(32)) b2 ();
  func_accum_stage_if #(.WIDTH(32)) b1 ();

  func_accum_stage #(.WIDTH(32), .COUNT(4), .INC(5)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  func_accum_stage #(.WIDTH(32), .COUNT(2), .INC(5)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  func_accum_stage #(.WIDTH(32), .COUNT(1), .INC(5)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        o;
  } res_t;

  typedef struct {
    logic [31:0] din [4];
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  res_t q4[$];
  res_t q2[$];
  res_t q1[$];
  res_t r4, r2, r1;
  vec_t vec [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] ed, input logic eo);
    vec[i].din[0] = a;
    vec[i].din[1] = b;
    vec[i].din[2] = c;
    vec[i].din[3] = d;
    vec[i].exp_d  = ed;
    vec[i].exp_o  = eo;
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      4:       return b4.in_ready;
      2:       return b2.in_ready;
      default: return b1.in_ready;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      4:       begin b4.in_valid = v; b4.in_data = d; end
      2:       begin b2.in_valid = v; b2.in_data = d; end
      default: begin b1.in_valid = v; b1.in_data = d; end
    endcase
  endtask

  // Present one operand, wait (bounded) for acceptance, return #1 after the accepting edge.
  task automatic send(input int sel, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    drive(sel, 1'b1, d);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = rdy(sel);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout dut=%0d got=no_ready exp=ready", sel);
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, d);
  endtask

  task automatic push(input int sel, input logic [31:0] d, input logic o);
    res_t r;
    r.d = d;
    r.o = o;
    case (sel)
      4:       q4.push_back(r);
      2:       q2.push_back(r);
      default: q1.push_back(r);
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n && b4.out_valid && b4.out_ready) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL u4_unexpected got=%h exp=none", b4.out_data);
      end else begin
        r4 = q4.pop_front();
        if (b4.out_data !== r4.d || b4.out_overflow !== r4.o) begin
          failures++;
          $display("FAIL u4_result got=%h/%b exp=%h/%b", b4.out_data, b4.out_overflow, r4.d, r4.o);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b2.out_valid && b2.out_ready) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL u2_unexpected got=%h exp=none", b2.out_data);
      end else begin
        r2 = q2.pop_front();
        if (b2.out_data !== r2.d || b2.out_overflow !== r2.o) begin
          failures++;
          $display("FAIL u2_result got=%h/%b exp=%h/%b", b2.out_data, b2.out_overflow, r2.d, r2.o);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.out_valid && b1.out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL u1_unexpected got=%h exp=none", b1.out_data);
      end else begin
        r1 = q1.pop_front();
        if (b1.out_data !== r1.d || b1.out_overflow !== r1.o) begin
          failures++;
          $display("FAIL u1_result got=%h/%b exp=%h/%b", b1.out_data, b1.out_overflow, r1.d, r1.o);
        end
      end
    end
  end

  initial begin
    int c0;

    // step(v) = v + 5; sums wrap at 2^32, ovf is any accumulation carry.
    set_vec(0, 32'd5, 32'd5, 32'd5, 32'd5, 32'd40, 1'b0);
    set_vec(1, 32'd0, 32'd1, 32'd2, 32'd3, 32'd26, 1'b0);
    set_vec(2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd42, 1'b0);
    set_vec(3, 32'd8, 32'd9, 32'd10, 32'd11, 32'd58, 1'b0);
    set_vec(4, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'd0, 32'd0, 32'd8, 1'b1);
    set_vec(5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd24, 1'b0);
    set_vec(6, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 32'd15, 1'b0);

    rst_n = 1'b0;
    drive(4, 1'b0, 32'd0);
    drive(2, 1'b0, 32'd0);
    drive(1, 1'b0, 32'd0);
    b4.out_ready = 1'b1;
    b2.out_ready = 1'b1;
    b1.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_out_data", b4.out_data, 32'd0);
    chk("rst_out_overflow", 32'(b4.out_overflow), 32'd0);
    chk("rst_busy", 32'(b4.busy), 32'd0);
    chk("rst_in_ready", 32'(b4.in_ready), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors streamed with no gaps; group boundaries must not cost a cycle.
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      push(4, vec[i].exp_d, vec[i].exp_o);
      for (int j = 0; j < 4; j++) send(4, vec[i].din[j]);
      chk("latency_out_valid", 32'(b4.out_valid), 32'd1);
      chk("latency_out_data", b4.out_data, vec[i].exp_d);
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd28);
    @(posedge clk);
    #1;
    chk("idle_after_stream", 32'(b4.busy), 32'd0);

    // Backpressure: result held with a waiting operand.
    b4.out_ready = 1'b0;
    push(4, 32'd40, 1'b0);
    for (int j = 0; j < 4; j++) send(4, 32'd5);
    push(4, 32'd24, 1'b0);
    drive(4, 1'b1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(b4.in_ready), 32'd0);
      chk("bp_out_valid", 32'(b4.out_valid), 32'd1);
      chk("bp_out_data", b4.out_data, 32'd40);
    end
    @(posedge clk);
    #1;
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(4, 1'b0, 32'd0);
    chk("bp_busy_after_drain", 32'(b4.busy), 32'd1);
    for (int j = 0; j < 3; j++) send(4, 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a group.
    send(4, 32'd9);
    send(4, 32'd9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(b4.busy), 32'd0);
    chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(b4.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_still_idle", 32'(b4.busy), 32'd0);
    push(4, 32'd24, 1'b0);
    for (int j = 0; j < 4; j++) send(4, 32'd1);
    chk("midrst_result", b4.out_data, 32'd24);

    // COUNT=2 with a carry, then a clean group clearing the flag.
    push(2, 32'd5, 1'b1);
    send(2, 32'hFFFF_FFFA);
    send(2, 32'd1);
    chk("c2_ovf_data", b2.out_data, 32'd5);
    chk("c2_ovf_flag", 32'(b2.out_overflow), 32'd1);
    push(2, 32'd10, 1'b0);
    send(2, 32'd0);
    send(2, 32'd0);
    chk("c2_clean_flag", 32'(b2.out_overflow), 32'd0);

    // COUNT=1: a result per operand, busy held through the stream.
    push(1, 32'd12, 1'b0);
    push(1, 32'd13, 1'b0);
    send(1, 32'd7);
    chk("c1_first_data", b1.out_data, 32'd12);
    chk("c1_first_busy", 32'(b1.busy), 32'd1);
    send(1, 32'd8);
    chk("c1_second_data", b1.out_data, 32'd13);
    chk("c1_second_busy", 32'(b1.busy), 32'd1);
    chk("c1_second_valid", 32'(b1.out_valid), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("c1_idle", 32'(b1.busy), 32'd0);
    chk("c2_idle", 32'(b2.busy), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
